otn_frame_tx: RTL and testbench
===============================

Name: otn_frame_tx

Overview:
- Line-side transmit stage of the sender path. Sits directly downstream of the mapper and consumes its byte-wide frame stream (data, valid, FAS marker).
- Captures whole frames into a ping-pong buffer, then serialises each frame onto the single-bit line output o_otn_tx_data.
- When ARQ is enabled, holds each frame until the receiver acknowledges it, retransmitting on timeout up to a retry limit.

Parameters:
- FRAME_BYTES, 64: bytes per frame, FAS byte included; legal range 2..256.
- ACK_TIMEOUT, 16'd50000: i_clk cycles spent in WAIT_ACK before a retransmit.
- MAX_RETRY, 3: retransmissions allowed after the first send before the frame is abandoned.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_bit_en  in  1  one-cycle line bit-rate strobe.
- i_frame_data  in  8  frame byte from the mapper.
- i_frame_data_valid  in  1  i_frame_data valid this cycle; there is no backpressure.
- i_frame_data_fas  in  1  qualifies byte 0 of a frame; meaningful only with valid.
- i_arq_en  in  1  enables ACK wait and retransmit.
- i_tx_ack  in  1  one-cycle ACK pulse from the return path.
- o_otn_tx_data  out  1  serial line; idles high.
- o_tx_busy  out  1  serialiser not IDLE.
- o_frame_done  out  1  pulse: frame released after successful send or ACK.
- o_tx_fail  out  1  pulse: frame abandoned after retries were exhausted.
- o_overflow  out  1  pulse: a complete frame was dropped because no buffer was free.
- o_frame_err  out  1  pulse: partial frame aborted by an early FAS.
- o_retry_cnt  out  2  retransmissions made for the current frame.

Behaviour:
- Reset state: o_otn_tx_data=1; every other output 0; both buffers invalid; write pointer 0; FSM in IDLE. Reset is asynchronous, so it takes effect mid-frame immediately and the line returns to 1.
- Capture, byte handling:
  - A valid byte with FAS=1 writes address 0 of the current fill buffer and sets the write pointer to 1.
  - A valid byte with FAS=0 writes at the write pointer, then the pointer increments.
  - Valid bytes arriving before any FAS are discarded.
- Capture, frame completion: on the write of byte FRAME_BYTES-1, the fill buffer is marked full and filling switches to the other buffer.
- Capture, boundary cases:
  - FAS while the pointer is not 0: pulse o_frame_err, discard the partial frame, store that byte as the new byte 0.
  - No free buffer when a FAS arrives: drop the whole frame and pulse o_overflow once, when its last byte would have been written.
- Serialiser framing: per byte, start bit 0, then 8 data bits LSB first, then stop bit 1. Bits update only on i_bit_en cycles.
- Serialiser ordering: bytes go out in address order. Buffers are sent oldest-first and alternate between buffer 0 and buffer 1.
- FSM transitions:
  - IDLE: a full buffer present at an i_bit_en goes to SEND, and the start bit of byte 0 is driven that same strobe.
  - SEND: bit counter runs 0..9, byte counter runs 0..FRAME_BYTES-1. After the last stop bit:
    - with i_arq_en=1, go to WAIT_ACK;
    - otherwise release the buffer, pulse o_frame_done, go to IDLE.
  - WAIT_ACK, entry: the timeout counter clears on entry, then counts i_clk cycles.
  - WAIT_ACK, ACK: i_tx_ack releases the buffer, pulses o_frame_done, clears o_retry_cnt, goes to IDLE.
  - WAIT_ACK, timeout: the counter reaching ACK_TIMEOUT-1 goes to RETRY.
  - WAIT_ACK, ACK and timeout in the same cycle: the ACK wins.
  - RETRY, retries left (o_retry_cnt<MAX_RETRY): increment o_retry_cnt, go to SEND from byte 0 at the next i_bit_en.
  - RETRY, retries exhausted: release the buffer, pulse o_tx_fail, clear o_retry_cnt, go to IDLE.
- i_tx_ack outside WAIT_ACK is ignored.
- i_arq_en is sampled once, at the end of SEND.
- Capture continues into the free buffer during SEND, WAIT_ACK and RETRY.
- A buffer release and a buffer-full event in the same cycle are both honoured.
- Throughput: back-to-back frames leave no idle bits between the last stop bit and the next start bit.

Decomposition:
- Shared package sender_pkg holds:
  - FSM state encoding: IDLE, SEND, WAIT_ACK, RETRY;
  - the line bit constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1;
  - BITS_PER_CHAR=10.
- One sub-module, otn_frame_buf: a dual-buffer byte RAM with per-buffer full flags and the write-pointer logic. The FSM and serialiser stay in otn_frame_tx.

Test Plan:
- FRAME_BYTES=4, arq off, i_bit_en every 4 cycles, bytes A5,01,02,03 with FAS on A5 -> line shows 0,10100101 LSB-first,1 for each byte; one o_frame_done; o_otn_tx_data returns to 1.
- arq on, ACK pulsed 10 cycles after the last stop bit -> o_frame_done, no retransmit, o_retry_cnt=0.
- arq on, ACK_TIMEOUT=20, no ACK, MAX_RETRY=3 -> 4 identical transmissions; o_retry_cnt goes 1,2,3; one o_tx_fail; buffer freed.
- Three back-to-back frames while the first waits for ACK -> second buffered, third dropped with one o_overflow; after ACK the second frame is sent.
- FAS after 2 bytes, then a full 4-byte frame -> one o_frame_err; only the later frame is transmitted.
- i_rst_n low mid-SEND -> line forced to 1 asynchronously; no pulses after reset release; the next full frame is sent normally.

Source files
------------

// File: rtl/sender_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : sender_pkg                                                   |
// | Shared definitions for the line-side transmit path: serialiser FSM     |
// | state encoding, line-level bit constants and a buffer address-width    |
// | helper.                                                                |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package sender_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2,
    RETRY    = 2'd3
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // start + 8 data + stop
  localparam int BITS_PER_CHAR = 10;

  // Address width for a frame buffer; never narrower than one bit.
  function automatic int addr_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : sender_pkg
`default_nettype wire

// File: rtl/otn_frame_buf.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : otn_frame_buf                                                |
// | Ping-pong frame store. Captures the mapper byte stream into whichever  |
// | buffer is being filled, flags a buffer full once its last byte lands,  |
// | and drops frames that find no free buffer.                             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
// | Ports                                                                  |
// |   i_clk, i_rst_n   clock, asynchronous active-low reset                |
// |   i_wr_valid       byte strobe from the mapper                         |
// |   i_wr_fas         byte is byte 0 of a frame                           |
// |   i_wr_data        frame byte                                          |
// |   i_rel/i_rel_buf  release (mark empty) the given buffer               |
// |   i_rd_buf/addr    read port select (combinational read)               |
// |   o_rd_data        byte at the read address                            |
// |   o_full           per-buffer full flags                               |
// |   o_overflow       pulse: a whole frame was dropped                    |
// |   o_frame_err      pulse: partial frame aborted by an early FAS        |
// +------------------------------------------------------------------------+
module otn_frame_buf
  import sender_pkg::*;
#(
  parameter int FRAME_BYTES = 64,
  parameter int AW          = addr_bits(FRAME_BYTES)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_valid,
  input  logic          i_wr_fas,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rel,
  input  logic          i_rel_buf,
  input  logic          i_rd_buf,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic [1:0]    o_full,
  output logic          o_overflow,
  output logic          o_frame_err
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_BYTES - 1);

  logic [7:0]    r_mem0 [0:FRAME_BYTES-1];
  logic [7:0]    r_mem1 [0:FRAME_BYTES-1];
  logic [1:0]    r_full;
  logic          r_fill;      // buffer currently being filled
  logic [AW-1:0] r_wr_ptr;
  logic          r_active;    // a FAS has been seen and the frame is in progress
  logic          r_drop;      // current frame found no free buffer
  logic          r_overflow;
  logic          r_frame_err;

  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_ptr_nxt;
  logic          w_active_nxt;
  logic          w_drop_nxt;
  logic          w_set_full;
  logic          w_ovf;
  logic          w_ferr;
  logic [1:0]    w_rel_mask;
  logic [1:0]    w_set_mask;

  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_addr    = r_wr_ptr;
    w_ptr_nxt    = r_wr_ptr;
    w_active_nxt = r_active;
    w_drop_nxt   = r_drop;
    w_set_full   = 1'b0;
    w_ovf        = 1'b0;
    w_ferr       = 1'b0;
    if (i_wr_valid) begin
      if (i_wr_fas) begin
        // A FAS always restarts the frame; a partial frame is abandoned.
        w_ferr       = (r_wr_ptr != '0);
        w_active_nxt = 1'b1;
        w_ptr_nxt    = AW'(1);
        w_wr_addr    = '0;
        w_drop_nxt   = r_full[r_fill];
        w_wr_en      = ~r_full[r_fill];
      end else if (r_active) begin
        // Pointer keeps counting while dropping so the overflow pulse
        // lands on the byte that would have completed the frame.
        w_wr_en = ~r_drop;
        if (r_wr_ptr == LAST_ADDR) begin
          w_ptr_nxt    = '0;
          w_active_nxt = 1'b0;
          w_drop_nxt   = 1'b0;
          w_set_full   = ~r_drop;
          w_ovf        = r_drop;
        end else begin
          w_ptr_nxt = r_wr_ptr + 1'b1;
        end
      end
    end
  end

  assign w_rel_mask = {i_rel & i_rel_buf, i_rel & ~i_rel_buf};
  assign w_set_mask = {w_set_full & r_fill, w_set_full & ~r_fill};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full      <= 2'b00;
      r_fill      <= 1'b0;
      r_wr_ptr    <= '0;
      r_active    <= 1'b0;
      r_drop      <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // Release and fill target different buffers, so both are honoured.
      r_full      <= (r_full & ~w_rel_mask) | w_set_mask;
      r_fill      <= r_fill ^ w_set_full;
      r_wr_ptr    <= w_ptr_nxt;
      r_active    <= w_active_nxt;
      r_drop      <= w_drop_nxt;
      r_overflow  <= w_ovf;
      r_frame_err <= w_ferr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      if (r_fill) r_mem1[w_wr_addr] <= i_wr_data;
      else        r_mem0[w_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data   = i_rd_buf ? r_mem1[i_rd_addr] : r_mem0[i_rd_addr];
  assign o_full      = r_full;
  assign o_overflow  = r_overflow;
  assign o_frame_err = r_frame_err;

endmodule : otn_frame_buf
`default_nettype wire

// File: rtl/otn_frame_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : otn_frame_tx                                                 |
// | Line-side transmit stage. Buffers whole frames from the mapper and     |
// | serialises them (start, 8 data LSB first, stop) at the line bit rate,  |
// | with optional ACK wait and timed retransmission.                       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
// | Ports                                                                  |
// |   i_clk, i_rst_n        clock, asynchronous active-low reset           |
// |   i_bit_en              line bit-rate strobe                           |
// |   i_frame_data/_valid/_fas  mapper byte stream                         |
// |   i_arq_en              enable ACK wait / retransmit                   |
// |   i_tx_ack              ACK pulse from the return path                 |
// |   o_otn_tx_data         serial line (idles high)                       |
// |   o_tx_busy             serialiser not idle                            |
// |   o_frame_done          pulse: frame released after send / ACK         |
// |   o_tx_fail             pulse: frame abandoned after retries           |
// |   o_overflow            pulse: whole frame dropped, no free buffer     |
// |   o_frame_err           pulse: partial frame aborted by early FAS      |
// |   o_retry_cnt           retransmissions made for the current frame     |
// +------------------------------------------------------------------------+
module otn_frame_tx
  import sender_pkg::*;
#(
  parameter int          FRAME_BYTES = 64,
  parameter logic [15:0] ACK_TIMEOUT = 16'd50000,
  parameter int          MAX_RETRY   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_bit_en,
  input  logic [7:0] i_frame_data,
  input  logic       i_frame_data_valid,
  input  logic       i_frame_data_fas,
  input  logic       i_arq_en,
  input  logic       i_tx_ack,
  output logic       o_otn_tx_data,
  output logic       o_tx_busy,
  output logic       o_frame_done,
  output logic       o_tx_fail,
  output logic       o_overflow,
  output logic       o_frame_err,
  output logic [1:0] o_retry_cnt
);

  localparam int            AW        = addr_bits(FRAME_BYTES);
  localparam logic [AW-1:0] LAST_BYTE = AW'(FRAME_BYTES - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(BITS_PER_CHAR - 1);
  localparam logic [3:0]    LAST_DATA = 4'(BITS_PER_CHAR - 2);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  tx_state_t     r_state;
  logic [3:0]    r_bit_cnt;   // position of the bit currently on the line
  logic [AW-1:0] r_byte_cnt;
  logic          r_rd_buf;    // oldest buffer, next to be sent
  logic [15:0]   r_to_cnt;
  logic [1:0]    r_retry;
  logic          r_tx;
  logic          r_frame_done;
  logic          r_tx_fail;

  tx_state_t     w_state_nxt;
  logic [3:0]    w_bit_nxt;
  logic [AW-1:0] w_byte_nxt;
  logic          w_rd_buf_nxt;
  logic [15:0]   w_to_nxt;
  logic [1:0]    w_retry_nxt;
  logic          w_tx_nxt;
  logic          w_done_nxt;
  logic          w_fail_nxt;
  logic          w_rel;
  logic [7:0]    w_rd_data;
  logic [1:0]    w_full;

  otn_frame_buf #(
    .FRAME_BYTES (FRAME_BYTES),
    .AW          (AW)
  ) u_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wr_valid  (i_frame_data_valid),
    .i_wr_fas    (i_frame_data_fas),
    .i_wr_data   (i_frame_data),
    .i_rel       (w_rel),
    .i_rel_buf   (r_rd_buf),
    .i_rd_buf    (r_rd_buf),
    .i_rd_addr   (r_byte_cnt),
    .o_rd_data   (w_rd_data),
    .o_full      (w_full),
    .o_overflow  (o_overflow),
    .o_frame_err (o_frame_err)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_rd_buf     <= 1'b0;
      r_to_cnt     <= '0;
      r_retry      <= '0;
      r_tx         <= IDLE_LEVEL;
      r_frame_done <= 1'b0;
      r_tx_fail    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_byte_cnt   <= w_byte_nxt;
      r_rd_buf     <= w_rd_buf_nxt;
      r_to_cnt     <= w_to_nxt;
      r_retry      <= w_retry_nxt;
      r_tx         <= w_tx_nxt;
      r_frame_done <= w_done_nxt;
      r_tx_fail    <= w_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bit_nxt    = r_bit_cnt;
    w_byte_nxt   = r_byte_cnt;
    w_rd_buf_nxt = r_rd_buf;
    w_to_nxt     = r_to_cnt;
    w_retry_nxt  = r_retry;
    w_tx_nxt     = r_tx;
    w_done_nxt   = 1'b0;
    w_fail_nxt   = 1'b0;
    w_rel        = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = IDLE_LEVEL;
        if (i_bit_en && w_full[r_rd_buf]) begin
          w_state_nxt = SEND;
          w_bit_nxt   = '0;
          w_byte_nxt  = '0;
          w_tx_nxt    = START_BIT;
        end
      end
      SEND: begin
        if (i_bit_en) begin
          if (r_bit_cnt != LAST_BIT) begin
            // Bit r_bit_cnt+1 goes out: data bits 0..7, then the stop bit.
            w_bit_nxt = r_bit_cnt + 4'd1;
            w_tx_nxt  = (r_bit_cnt == LAST_DATA) ? STOP_BIT : w_rd_data[r_bit_cnt[2:0]];
          end else if (r_byte_cnt != LAST_BYTE) begin
            w_byte_nxt = r_byte_cnt + 1'b1;
            w_bit_nxt  = '0;
            w_tx_nxt   = START_BIT;
          end else if (i_arq_en) begin
            w_state_nxt = WAIT_ACK;
            w_to_nxt    = '0;
            w_tx_nxt    = IDLE_LEVEL;
          end else begin
            w_rel        = 1'b1;
            w_done_nxt   = 1'b1;
            w_rd_buf_nxt = ~r_rd_buf;
            // Chain straight into the other buffer to avoid idle bits.
            if (w_full[~r_rd_buf]) begin
              w_bit_nxt  = '0;
              w_byte_nxt = '0;
              w_tx_nxt   = START_BIT;
            end else begin
              w_state_nxt = IDLE;
              w_tx_nxt    = IDLE_LEVEL;
            end
          end
        end
      end
      WAIT_ACK: begin
        w_tx_nxt = IDLE_LEVEL;
        if (i_tx_ack) begin
          w_rel        = 1'b1;
          w_done_nxt   = 1'b1;
          w_retry_nxt  = '0;
          w_rd_buf_nxt = ~r_rd_buf;
          w_state_nxt  = IDLE;
        end else if (r_to_cnt == ACK_TIMEOUT - 16'd1) begin
          w_state_nxt = RETRY;
        end else begin
          w_to_nxt = r_to_cnt + 16'd1;
        end
      end
      RETRY: begin
        w_tx_nxt = IDLE_LEVEL;
        if (r_retry < RETRY_MAX) begin
          if (i_bit_en) begin
            w_retry_nxt = r_retry + 2'd1;
            w_state_nxt = SEND;
            w_bit_nxt   = '0;
            w_byte_nxt  = '0;
            w_tx_nxt    = START_BIT;
          end
        end else begin
          w_rel        = 1'b1;
          w_fail_nxt   = 1'b1;
          w_retry_nxt  = '0;
          w_rd_buf_nxt = ~r_rd_buf;
          w_state_nxt  = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = IDLE_LEVEL;
      end
    endcase
  end

  assign o_otn_tx_data = r_tx;
  assign o_tx_busy     = (r_state != IDLE);
  assign o_frame_done  = r_frame_done;
  assign o_tx_fail     = r_tx_fail;
  assign o_retry_cnt   = r_retry;

endmodule : otn_frame_tx
`default_nettype wire

// File: tb/tb_otn_frame_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_otn_frame_tx                                              |
// | Directed bench for otn_frame_tx: decodes the serial line back into     |
// | bytes and checks them, event pulses and retry counts against           |
// | hand-computed expectations.                                            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_otn_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_en = 1'b0;
  logic [7:0] fdata = 8'h00;
  logic       fvalid = 1'b0;
  logic       ffas = 1'b0;
  logic       arq_en = 1'b0;
  logic       tx_ack = 1'b0;
  logic       o_otn_tx_data;
  logic       o_tx_busy;
  logic       o_frame_done;
  logic       o_tx_fail;
  logic       o_overflow;
  logic       o_frame_err;
  logic [1:0] o_retry_cnt;

  otn_frame_tx #(
    .FRAME_BYTES (4),
    .ACK_TIMEOUT (16'd20),
    .MAX_RETRY   (3)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_bit_en           (bit_en),
    .i_frame_data       (fdata),
    .i_frame_data_valid (fvalid),
    .i_frame_data_fas   (ffas),
    .i_arq_en           (arq_en),
    .i_tx_ack           (tx_ack),
    .o_otn_tx_data      (o_otn_tx_data),
    .o_tx_busy          (o_tx_busy),
    .o_frame_done       (o_frame_done),
    .o_tx_fail          (o_tx_fail),
    .o_overflow         (o_overflow),
    .o_frame_err        (o_frame_err),
    .o_retry_cnt        (o_retry_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit strobe every 4 clocks, changed on the falling edge.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(negedge clk);
      phase = (phase + 1) % 4;
      bit_en = (phase == 0);
    end
  end

  // Line decoder: start(0), 8 data LSB first, stop(1), sampled per strobe.
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         stop_err = 0;
  initial begin
    int dstate;
    int sc;
    logic [7:0] dbyte;
    dstate = 0;
    sc = 0;
    dbyte = 8'h00;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        dstate = 0;
      end else if (bit_en) begin
        #1;
        sc++;
        if (dstate == 0) begin
          if (o_otn_tx_data == 1'b0) begin
            dstate = 1;
            start_q.push_back(sc);
          end
        end else if (dstate <= 8) begin
          dbyte[dstate-1] = o_otn_tx_data;
          dstate++;
        end else begin
          if (o_otn_tx_data !== 1'b1) stop_err++;
          rx_q.push_back(dbyte);
          dstate = 0;
        end
      end
    end
  end

  // Pulse counters and retry-count history.
  int n_done = 0, n_fail = 0, n_ovf = 0, n_err = 0;
  int retry_q[$];
  initial begin
    logic [1:0] last_retry;
    last_retry = 2'd0;
    forever begin
      @(negedge clk);
      if (o_frame_done) n_done++;
      if (o_tx_fail)    n_fail++;
      if (o_overflow)   n_ovf++;
      if (o_frame_err)  n_err++;
      if (o_retry_cnt != last_retry) begin
        retry_q.push_back(int'(o_retry_cnt));
        last_retry = o_retry_cnt;
      end
    end
  end

  task automatic put_byte(input logic [7:0] d, input logic fas);
    @(negedge clk);
    fdata  = d;
    fvalid = 1'b1;
    ffas   = fas;
  endtask

  task automatic stop_in();
    @(negedge clk);
    fvalid = 1'b0;
    ffas   = 1'b0;
  endtask

  task automatic put_frame(input logic [31:0] f);
    put_byte(f[31:24], 1'b1);
    put_byte(f[23:16], 1'b0);
    put_byte(f[15:8],  1'b0);
    put_byte(f[7:0],   1'b0);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_bytes", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (o_tx_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle", int'(o_tx_busy), 0);
  endtask

  task automatic chk_frame(input string tag, input int base, input logic [31:0] f);
    logic [7:0] g;
    for (int i = 0; i < 4; i++) begin
      g = (base + i < rx_q.size()) ? rx_q[base+i] : 8'hxx;
      chk(tag, int'(g), int'(f[31-8*i -: 8]));
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    start_q.delete();
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
  endtask

  initial begin
    int d0, f0, o0, e0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_line",  int'(o_otn_tx_data), 1);
    chk("rst_busy",  int'(o_tx_busy), 0);
    chk("rst_done",  int'(o_frame_done), 0);
    chk("rst_fail",  int'(o_tx_fail), 0);
    chk("rst_ovf",   int'(o_overflow), 0);
    chk("rst_ferr",  int'(o_frame_err), 0);
    chk("rst_retry", int'(o_retry_cnt), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Plain send, ARQ off
    clear_rx();
    put_frame(32'hA5010203);
    stop_in();
    wait_bytes(4, 1000);
    wait_idle(100);
    chk_frame("t1_bytes", 0, 32'hA5010203);
    chk("t1_stop", stop_err, 0);
    chk("t1_done", n_done, 1);
    chk("t1_line", int'(o_otn_tx_data), 1);

    // ARQ on, ACK shortly after the last stop bit
    clear_rx();
    arq_en = 1'b1;
    put_frame(32'h11223344);
    stop_in();
    wait_bytes(4, 1000);
    repeat (9) @(negedge clk);
    chk("t2_busy_wait", int'(o_tx_busy), 1);
    ack_pulse();
    repeat (200) @(negedge clk);
    chk("t2_nbytes", rx_q.size(), 4);
    chk_frame("t2_bytes", 0, 32'h11223344);
    chk("t2_done", n_done, 2);
    chk("t2_retry", int'(o_retry_cnt), 0);
    chk("t2_busy", int'(o_tx_busy), 0);

    // ARQ on, never acknowledged: 4 sends, then failure
    clear_rx();
    retry_q.delete();
    put_frame(32'h55667788);
    stop_in();
    wait_bytes(16, 4000);
    wait_idle(200);
    for (int t = 0; t < 4; t++) chk_frame("t3_bytes", 4*t, 32'h55667788);
    chk("t3_fail", n_fail, 1);
    chk("t3_done", n_done, 2);
    chk("t3_rq_n", retry_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t3_rq", (i < retry_q.size()) ? retry_q[i] : -1, (i < 3) ? i + 1 : 0);
    repeat (100) @(negedge clk);
    chk("t3_nbytes", rx_q.size(), 16);

    // Three frames while the first waits for ACK: third is dropped
    clear_rx();
    put_frame(32'hAA010203);
    put_frame(32'hBB040506);
    put_frame(32'hCC070809);
    stop_in();
    repeat (3) @(negedge clk);
    chk("t4_ovf", n_ovf, 1);
    wait_bytes(4, 1000);
    repeat (9) @(negedge clk);
    arq_en = 1'b0;
    ack_pulse();
    wait_bytes(8, 1000);
    wait_idle(100);
    repeat (100) @(negedge clk);
    chk("t4_nbytes", rx_q.size(), 8);
    chk_frame("t4_f1", 0, 32'hAA010203);
    chk_frame("t4_f2", 4, 32'hBB040506);
    chk("t4_done", n_done, 4);
    chk("t4_ovf_end", n_ovf, 1);

    // Back-to-back frames leave no idle bits between them
    clear_rx();
    put_frame(32'hD0D1D2D3);
    put_frame(32'hE0E1E2E3);
    stop_in();
    wait_bytes(8, 1000);
    wait_idle(100);
    chk_frame("t5_f1", 0, 32'hD0D1D2D3);
    chk_frame("t5_f2", 4, 32'hE0E1E2E3);
    chk("t5_gap",  (start_q.size() >= 5) ? start_q[4] - start_q[3] : -1, 10);
    chk("t5_char", (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1, 10);
    chk("t5_done", n_done, 6);

    // Stray bytes, then an early FAS aborts a partial frame
    clear_rx();
    put_byte(8'hEE, 1'b0);
    put_byte(8'hEF, 1'b0);
    put_byte(8'hF0, 1'b1);
    put_byte(8'hF1, 1'b0);
    put_frame(32'h10203040);
    stop_in();
    wait_bytes(4, 1000);
    wait_idle(100);
    repeat (100) @(negedge clk);
    chk("t6_nbytes", rx_q.size(), 4);
    chk_frame("t6_bytes", 0, 32'h10203040);
    chk("t6_ferr", n_err, 1);
    chk("t6_ovf", n_ovf, 1);
    chk("t6_done", n_done, 7);

    // Asynchronous reset in the middle of a send
    clear_rx();
    put_frame(32'h99009796);
    stop_in();
    wait_bytes(1, 1000);
    repeat (12) @(negedge clk);
    chk("t7_line_low", int'(o_otn_tx_data), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_line_rst", int'(o_otn_tx_data), 1);
    chk("t7_busy_rst", int'(o_tx_busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_rx();
    d0 = n_done; f0 = n_fail; o0 = n_ovf; e0 = n_err;
    repeat (200) @(negedge clk);
    chk("t7_quiet_bytes", rx_q.size(), 0);
    chk("t7_quiet_pulses", (n_done - d0) + (n_fail - f0) + (n_ovf - o0) + (n_err - e0), 0);
    put_frame(32'h5A5B5C5D);
    stop_in();
    wait_bytes(4, 1000);
    wait_idle(100);
    chk_frame("t7_bytes", 0, 32'h5A5B5C5D);
    chk("t7_done", n_done - d0, 1);
    chk("t7_line", int'(o_otn_tx_data), 1);
    chk("stop_bits", stop_err, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_otn_frame_tx
`default_nettype wire
